// File: rtl/ball_motion.sv
// Per-frame ball physics for the table game: integrates position, bounces off the walls,
// applies friction, and detects capture by the hole before the sprite renderer sees x/y.
module ball_motion #(
    parameter int FRAC        = 4,
    parameter int X_MIN       = 16,
    parameter int X_MAX       = 1008,
    parameter int Y_MIN       = 16,
    parameter int Y_MAX       = 752,
    parameter int BALL_SIZE   = 16,
    parameter int HOME_X      = 100,
    parameter int HOME_Y      = 376,
    parameter int FRIC_SHIFT  = 5,
    parameter int STOP_THR    = 2,
    parameter int HOLE_R      = 6,
    parameter int SINK_VMAX   = 48,
    parameter int SINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        launch,
    input  logic [11:0] launch_vx,
    input  logic [11:0] launch_vy,
    input  logic        new_round,
    input  logic [10:0] hole_x,
    input  logic [9:0]  hole_y,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [1:0]  ball_state,
    output logic        moving,
    output logic        sunk
);

    localparam int PW = 16 + FRAC;
    localparam int CW = $clog2(SINK_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MOVING  = 2'd1,
        S_SINKING = 2'd2,
        S_HIDDEN  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic            r_sunk;
    logic            r_moving;
    logic [1:0]      r_ball_state;
    logic            w_sunk_next;
    logic            w_moving_next;
    logic [1:0]      w_ball_state_next;

    // Index 0 is the x axis, index 1 the y axis.
    logic [1:0][11:0]   w_launch_v;
    logic [1:0][10:0]   w_hole;
    logic [1:0][PW-1:0] w_pos;
    logic [1:0]         w_near;
    logic [1:0]         w_slow;
    logic [1:0]         w_still;

    logic w_take_launch;
    logic w_step;
    logic w_capture;
    logic w_stop;
    logic w_sink_done;

    function automatic logic signed [11:0] f_friction(input logic signed [11:0] v);
        logic signed [11:0] d;
        d = v >>> FRIC_SHIFT;
        // Positive speeds below 2^FRIC_SHIFT would otherwise never decay.
        if (v > 12'sd0 && d == 12'sd0) begin
            f_friction = v - 12'sd1;
        end else begin
            f_friction = v - d;
        end
    endfunction

    function automatic logic [11:0] f_abs(input logic signed [11:0] v);
        f_abs = v[11] ? 12'(-v) : 12'(v);
    endfunction

    assign w_launch_v    = {launch_vy, launch_vx};
    assign w_hole        = {{1'b0, hole_y}, hole_x};
    assign w_take_launch = !new_round && (r_state == S_IDLE) && launch;
    assign w_step        = !new_round && (r_state == S_MOVING) && frame_tick;
    assign w_capture     = (&w_near) && (&w_slow);
    assign w_stop        = &w_still;
    assign w_sink_done   = (r_cnt == CW'(SINK_FRAMES - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam int LO_PX   = (gi == 0) ? X_MIN : Y_MIN;
            localparam int HI_PX   = (gi == 0) ? (X_MAX - BALL_SIZE) : (Y_MAX - BALL_SIZE);
            localparam int HOME_PX = (gi == 0) ? HOME_X : HOME_Y;
            localparam logic signed [PW+1:0] LO_Q      = (PW+2)'(LO_PX * (2 ** FRAC));
            localparam logic signed [PW+1:0] HI_EDGE_Q = (PW+2)'((HI_PX + 1) * (2 ** FRAC));
            localparam logic [PW-1:0]        LO_POS    = PW'(LO_PX * (2 ** FRAC));
            localparam logic [PW-1:0]        HI_POS    = PW'(HI_PX * (2 ** FRAC));
            localparam logic [PW-1:0]        HOME_POS  = PW'(HOME_PX * (2 ** FRAC));

            logic [PW-1:0]        r_pos;
            logic signed [11:0]   r_vel;
            logic signed [PW+1:0] w_np;
            logic                 w_hit_lo;
            logic                 w_hit_hi;
            logic [PW-1:0]        w_pos_clamp;
            logic signed [11:0]   w_vel_bounce;
            logic signed [11:0]   w_vel_fric;
            logic signed [17:0]   w_ctr_diff;

            // Two guard bits so an overshoot past either wall is seen before it wraps.
            assign w_np         = $signed({2'b00, r_pos}) + $signed({{(PW-10){r_vel[11]}}, r_vel});
            assign w_hit_lo     = (w_np < LO_Q);
            assign w_hit_hi     = (w_np >= HI_EDGE_Q);
            assign w_pos_clamp  = w_hit_lo ? LO_POS : (w_hit_hi ? HI_POS : w_np[PW-1:0]);
            assign w_vel_bounce = (w_hit_lo || w_hit_hi) ? -r_vel : r_vel;
            assign w_vel_fric   = f_friction(w_vel_bounce);

            assign w_ctr_diff   = $signed({2'b00, w_pos_clamp[PW-1:FRAC]})
                                + $signed(18'(BALL_SIZE / 2))
                                - $signed({7'b0, w_hole[gi]});
            assign w_near[gi]   = (w_ctr_diff <= $signed(18'(HOLE_R)))
                               && (w_ctr_diff >= -$signed(18'(HOLE_R)));
            assign w_slow[gi]   = (f_abs(r_vel) <= 12'(SINK_VMAX));
            assign w_still[gi]  = (f_abs(w_vel_fric) < 12'(STOP_THR));
            assign w_pos[gi]    = r_pos;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pos <= HOME_POS;
                    r_vel <= '0;
                end else if (new_round) begin
                    r_pos <= HOME_POS;
                    r_vel <= '0;
                end else if (w_take_launch) begin
                    r_vel <= $signed(w_launch_v[gi]);
                end else if (w_step) begin
                    r_pos <= w_pos_clamp;
                    r_vel <= (w_capture || w_stop) ? 12'sd0 : w_vel_fric;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (new_round) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (launch) w_state_next = S_MOVING;
                end
                S_MOVING: begin
                    // Capture outranks stop: a slow ball over the hole drops in.
                    if (frame_tick) begin
                        if (w_capture)   w_state_next = S_SINKING;
                        else if (w_stop) w_state_next = S_IDLE;
                    end
                end
                S_SINKING: begin
                    if (frame_tick && w_sink_done) w_state_next = S_HIDDEN;
                end
                S_HIDDEN: begin
                    w_state_next = S_HIDDEN;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_moving_next     = (w_state_next == S_MOVING);
        w_sunk_next       = (r_state == S_MOVING) && (w_state_next == S_SINKING);
        w_ball_state_next = 2'd0;
        case (w_state_next)
            S_SINKING: w_ball_state_next = 2'd1;
            S_HIDDEN:  w_ball_state_next = 2'd2;
            default:   w_ball_state_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_sunk       <= 1'b0;
            r_moving     <= 1'b0;
            r_ball_state <= 2'd0;
        end else begin
            r_sunk       <= w_sunk_next;
            r_moving     <= w_moving_next;
            r_ball_state <= w_ball_state_next;
            if (new_round || r_state != S_SINKING) begin
                r_cnt <= '0;
            end else if (frame_tick) begin
                r_cnt <= w_sink_done ? '0 : r_cnt + CW'(1);
            end
        end
    end

    assign x          = w_pos[0][PW-1:FRAC];
    assign y          = w_pos[1][PW-1:FRAC];
    assign ball_state = r_ball_state;
    assign moving     = r_moving;
    assign sunk       = r_sunk;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: an integer reference model predicts every cycle's
// outputs, expectations are queued when stimulus is driven and popped when the DUT answers.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        launch;
    logic [11:0] launch_vx;
    logic [11:0] launch_vy;
    logic        new_round;
    logic [10:0] hole_x;
    logic [9:0]  hole_y;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  ball_state;
    logic        moving;
    logic        sunk;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .launch     (launch),
        .launch_vx  (launch_vx),
        .launch_vy  (launch_vy),
        .new_round  (new_round),
        .hole_x     (hole_x),
        .hole_y     (hole_y),
        .x          (x),
        .y          (y),
        .ball_state (ball_state),
        .moving     (moving),
        .sunk       (sunk)
    );

    typedef struct {
        int ex;
        int ey;
        int ebs;
        int emv;
        int esk;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    // Reference model state (raw Q4 positions, raw velocities).
    int m_px, m_py, m_vx, m_vy, m_st, m_cnt, m_sk;
    int m_hx, m_hy;

    task automatic check(input string tag, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int fric(input int v);
        int d;
        if (v > 0) begin
            d = v / 32;
            return (d == 0) ? v - 1 : v - d;
        end else if (v < 0) begin
            d = -((-v + 31) / 32);
            return v - d;
        end
        return 0;
    endfunction

    task automatic model_home();
        m_px = 100 * 16; m_py = 376 * 16;
        m_vx = 0; m_vy = 0; m_st = 0; m_cnt = 0; m_sk = 0;
    endtask

    task automatic model_step();
        int nx, ny, bvx, bvy, fx, fy, cx, cy;
        nx = m_px + m_vx; ny = m_py + m_vy;
        bvx = m_vx; bvy = m_vy;
        if (nx < 16 * 16)        begin nx = 16 * 16;  bvx = -m_vx; end
        else if (nx >= 993 * 16) begin nx = 992 * 16; bvx = -m_vx; end
        if (ny < 16 * 16)        begin ny = 16 * 16;  bvy = -m_vy; end
        else if (ny >= 737 * 16) begin ny = 736 * 16; bvy = -m_vy; end
        cx = nx / 16 + 8; cy = ny / 16 + 8;
        if (iabs(cx - m_hx) <= 6 && iabs(cy - m_hy) <= 6 && iabs(m_vx) <= 48 && iabs(m_vy) <= 48) begin
            m_vx = 0; m_vy = 0; m_st = 2; m_cnt = 0; m_sk = 1;
        end else begin
            fx = fric(bvx); fy = fric(bvy);
            if (iabs(fx) < 2 && iabs(fy) < 2) begin
                m_vx = 0; m_vy = 0; m_st = 0;
            end else begin
                m_vx = fx; m_vy = fy;
            end
        end
        m_px = nx; m_py = ny;
    endtask

    task automatic model_cycle(input bit tk, input bit lc, input bit nr, input int lvx, input int lvy);
        m_sk = 0;
        if (nr) begin
            model_home();
        end else begin
            case (m_st)
                0: if (lc) begin m_vx = lvx; m_vy = lvy; m_st = 1; end
                1: if (tk) model_step();
                2: if (tk) begin
                       m_cnt++;
                       if (m_cnt == 30) begin m_st = 3; m_cnt = 0; end
                   end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input bit tk, input bit lc, input bit nr, input int lvx, input int lvy,
                         input string tag);
        exp_t e;
        frame_tick = tk; launch = lc; new_round = nr;
        launch_vx = 12'(lvx); launch_vy = 12'(lvy);
        hole_x = 11'(m_hx); hole_y = 10'(m_hy);
        model_cycle(tk, lc, nr, lvx, lvy);
        e.ex = m_px / 16; e.ey = m_py / 16;
        e.ebs = (m_st == 2) ? 1 : ((m_st == 3) ? 2 : 0);
        e.emv = (m_st == 1) ? 1 : 0;
        e.esk = m_sk;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        frame_tick = 1'b0; launch = 1'b0; new_round = 1'b0;
        e = q_exp.pop_front();
        n_txn++;
        check({tag, "_x"}, int'(x), e.ex);
        check({tag, "_y"}, int'(y), e.ey);
        check({tag, "_state"}, int'(ball_state), e.ebs);
        check({tag, "_moving"}, int'(moving), e.emv);
        check({tag, "_sunk"}, int'(sunk), e.esk);
        $display("txn %0d %s: x=%0d y=%0d st=%0d mv=%0d sk=%0d", n_txn, tag, x, y, ball_state, moving, sunk);
    endtask

    // A frame tick followed by one quiet cycle, so sunk must fall back to 0.
    task automatic tick(input string tag);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, tag);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, "gap");
    endtask

    task automatic run_until_rest(input string tag);
        for (int i = 0; i < 400 && m_st == 1; i++) tick(tag);
        check({tag, "_rest_bound"}, int'(moving), 0);
    endtask

    initial begin
        reset_n = 1'b0; frame_tick = 1'b0; launch = 1'b0; new_round = 1'b0;
        launch_vx = '0; launch_vy = '0;
        m_hx = 900; m_hy = 700;
        hole_x = 11'(m_hx); hole_y = 10'(m_hy);
        model_home();
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", int'(x), 100);
        check("reset_y", int'(y), 376);
        check("reset_state", int'(ball_state), 0);
        check("reset_moving", int'(moving), 0);
        check("reset_sunk", int'(sunk), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) tick("idle_tick");

        cycle(1'b0, 1'b1, 1'b0, 160, 0, "launch160");
        for (int i = 0; i < 3; i++) tick("move160");
        cycle(1'b0, 1'b1, 1'b0, -500, 0, "launch_ignored");
        run_until_rest("decay160");
        for (int i = 0; i < 3; i++) tick("at_rest");

        cycle(1'b0, 1'b0, 1'b1, 0, 0, "new_round");
        cycle(1'b0, 1'b1, 1'b0, 600, 0, "launch600");
        run_until_rest("right_wall");

        cycle(1'b0, 1'b0, 1'b1, 0, 0, "new_round");
        cycle(1'b0, 1'b1, 1'b0, 300, 900, "launch_dn");
        run_until_rest("bottom_wall");

        cycle(1'b0, 1'b0, 1'b1, 0, 0, "new_round");
        cycle(1'b0, 1'b1, 1'b0, -544, -2040, "launch_ul");
        run_until_rest("corner");

        // Hole close to the home line: a gentle roll drops in.
        m_hx = 125; m_hy = 384;
        cycle(1'b0, 1'b0, 1'b1, 0, 0, "new_round");
        cycle(1'b0, 1'b1, 1'b0, 32, 0, "launch32");
        run_until_rest("to_hole");
        for (int i = 0; i < 32; i++) tick("sinking");
        cycle(1'b0, 1'b1, 1'b0, 200, 0, "launch_hidden");
        tick("hidden");

        cycle(1'b0, 1'b0, 1'b1, 0, 0, "new_round");
        cycle(1'b0, 1'b1, 1'b0, 200, 0, "launch200");
        run_until_rest("pass_over");

        // new_round arriving together with the 10th sinking tick wins.
        cycle(1'b0, 1'b0, 1'b1, 0, 0, "new_round");
        cycle(1'b0, 1'b1, 1'b0, 32, 0, "launch32b");
        run_until_rest("to_hole_b");
        for (int i = 0; i < 9; i++) tick("sinking_b");
        cycle(1'b1, 1'b0, 1'b1, 0, 0, "nr_tick10");
        cycle(1'b1, 1'b1, 1'b0, 160, 0, "launch_tick");
        tick("first_move");
        tick("second_move");

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_x", int'(x), 100);
        check("async_y", int'(y), 376);
        check("async_moving", int'(moving), 0);
        model_home();
        @(negedge clk);
        reset_n = 1'b1;
        tick("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
